// File: rtl/spi_regs_pkg.sv
// Shared constants and the core-port FSM state type for the SPI register bank.
package spi_regs_pkg;
    localparam int unsigned DEF_ADDR_W       = 5;
    localparam int unsigned DEF_RW_REG_COUNT = 23;
    localparam int unsigned DEF_COMMIT_ADDR  = DEF_RW_REG_COUNT - 1;
    localparam int unsigned ERR_CNT_W        = 8;

    typedef enum logic [1:0] {
        IDLE,
        BLOCKED,
        ACK
    } core_state_e;
endpackage

// File: rtl/reg_core_port_fsm.sv
// Core write-port handshake: grants a write when no SPI strobe is present and acks it one cycle later.
module reg_core_port_fsm
    import spi_regs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic core_req,
    input  logic spi_busy,
    output logic grant,
    output logic core_ack
);

    core_state_e state;

    // ACK ignores core_req so a held request cannot double-commit.
    always_comb grant = core_req && !spi_busy && (state != ACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            core_ack <= 1'b0;
        end else begin
            core_ack <= grant;
            case (state)
                IDLE:    if (core_req) state <= spi_busy ? BLOCKED : ACK;
                BLOCKED: if (!core_req) state <= IDLE;
                         else if (!spi_busy) state <= ACK;
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Register bank shared by SPI write strobes (priority) and a core req/ack port.
// Optional shadow bank with commit register when SPI_REG_SHADOW_EN is defined.
module spi_reg_arbiter
    import spi_regs_pkg::*;
#(
    parameter int unsigned RW_REG_COUNT = DEF_RW_REG_COUNT,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned COMMIT_ADDR  = RW_REG_COUNT - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         spi_address,
    input  logic [7:0]                spi_data,
    input  logic                      is_spi_write,
    input  logic                      core_req,
    input  logic [ADDR_W-1:0]         core_addr,
    input  logic [7:0]                core_data,
    output logic                      core_ack,
    output logic [RW_REG_COUNT*8-1:0] rw_data,
    output logic [RW_REG_COUNT-1:0]   reg_changed,
    output logic [ERR_CNT_W-1:0]      write_err_cnt
);

    if ((1 << ADDR_W) < RW_REG_COUNT || COMMIT_ADDR >= RW_REG_COUNT) begin : g_bad_cfg
        $error("spi_reg_arbiter: ADDR_W too small or COMMIT_ADDR out of range");
    end

    logic                    core_grant;
    logic [RW_REG_COUNT-1:0] spi_hit;
    logic [RW_REG_COUNT-1:0] core_hit;
    logic                    err_hit;

    reg_core_port_fsm u_core_fsm (
        .clk      (clk),
        .rst      (rst),
        .core_req (core_req),
        .spi_busy (is_spi_write),
        .grant    (core_grant),
        .core_ack (core_ack)
    );

    // Out-of-range addresses match no bit, so they fall through to err_hit only.
    always_comb begin
        spi_hit  = '0;
        core_hit = '0;
        for (int unsigned i = 0; i < RW_REG_COUNT; i++) begin
            spi_hit[i]  = is_spi_write && (32'(spi_address) == i);
            core_hit[i] = core_grant && (32'(core_addr) == i);
        end
        err_hit = (is_spi_write && (32'(spi_address) >= RW_REG_COUNT))
               || (core_grant && (32'(core_addr) >= RW_REG_COUNT));
    end

`ifdef SPI_REG_SHADOW_EN
    logic [RW_REG_COUNT*8-1:0] shadow;
    logic                      commit;

    always_comb commit = spi_hit[COMMIT_ADDR] && spi_data[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else begin
            for (int unsigned i = 0; i < RW_REG_COUNT; i++) begin
                if (spi_hit[i] && (i != COMMIT_ADDR)) shadow[8*i +: 8] <= spi_data;
                if (core_hit[i])                      shadow[8*i +: 8] <= core_data;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_data       <= '0;
            reg_changed   <= '0;
            write_err_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < RW_REG_COUNT; i++) begin
`ifdef SPI_REG_SHADOW_EN
                if (commit && (i != COMMIT_ADDR)) rw_data[8*i +: 8] <= shadow[8*i +: 8];
`else
                if (spi_hit[i]) rw_data[8*i +: 8] <= spi_data;
`endif
                if (core_hit[i]) rw_data[8*i +: 8] <= core_data;
            end
`ifdef SPI_REG_SHADOW_EN
            reg_changed <= commit ? '1 : core_hit;
`else
            reg_changed <= spi_hit | core_hit;
`endif
            if (err_hit && (write_err_cnt != '1))
                write_err_cnt <= write_err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule
